// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard and sequencing controller for a 5-stage RISC-V pipeline.
//             Produces stall/flush controls for the pipeline registers,
//             EX-stage operand forwarding selects, a data-memory wait state
//             machine with timeout, and a saturating memory-stall counter.
//
//  Ports    :
//    clk_i          clock, all state updates on posedge
//    reset_i        synchronous active-high reset
//    rs1d_i/rs2d_i  source registers of the instruction in ID
//    rs1e_i/rs2e_i  source registers of the instruction in EX
//    rde_i          destination register of the instruction in EX
//    resultsrce0_i  instruction in EX is a load
//    pcsrce_i       taken branch/jump resolved in EX
//    regwritem_i    MEM-stage instruction writes rdm_i
//    rdm_i          destination register in MEM
//    regwritew_i    WB-stage instruction writes rdw_i
//    rdw_i          destination register in WB
//    memreqm_i      MEM-stage instruction accesses data memory
//    memreadym_i    data memory completes the access this cycle
//    stallf_o       hold PC
//    stalld_o       hold IF/ID
//    stalle_o       hold ID/EX
//    stallm_o       hold EX/MEM
//    flushd_o       clear IF/ID
//    flushe_o       clear ID/EX
//    flushw_o       load a bubble into MEM/WB
//    forwardae_o    EX operand A select (00 regfile, 01 WB, 10 MEM)
//    forwardbe_o    EX operand B select, same encoding
//    memerr_o       sticky memory-timeout error
//    stallcnt_o     saturating count of memory-stall cycles
//
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs1d_i,
  input  logic [4:0]       rs2d_i,
  input  logic [4:0]       rs1e_i,
  input  logic [4:0]       rs2e_i,
  input  logic [4:0]       rde_i,
  input  logic             resultsrce0_i,
  input  logic             pcsrce_i,
  input  logic             regwritem_i,
  input  logic [4:0]       rdm_i,
  input  logic             regwritew_i,
  input  logic [4:0]       rdw_i,
  input  logic             memreqm_i,
  input  logic             memreadym_i,
  output logic             stallf_o,
  output logic             stalld_o,
  output logic             stalle_o,
  output logic             stallm_o,
  output logic             flushd_o,
  output logic             flushe_o,
  output logic             flushw_o,
  output logic [1:0]       forwardae_o,
  output logic [1:0]       forwardbe_o,
  output logic             memerr_o,
  output logic [CNT_W-1:0] stallcnt_o
);

  // Wait counter only ever needs to reach MEM_TIMEOUT-1.
  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              memerr_q,   memerr_d;
  logic [CNT_W-1:0]  stallcnt_q, stallcnt_d;

  logic memstall;
  logic lwstall;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  always_comb begin
    memstall = 1'b0;
    case (state_q)
      ST_RUN:      memstall = memreqm_i & ~memreadym_i;
      ST_MEM_WAIT: memstall = ~memreadym_i;
      ST_ERR:      memstall = 1'b1;
      default:     memstall = 1'b0;
    endcase
  end

  assign lwstall = resultsrce0_i & (rde_i != 5'd0) &
                   ((rde_i == rs1d_i) | (rde_i == rs2d_i));

  // --------------------------------------------------------------------------
  // Stall / flush / forwarding outputs. Everything is forced quiet while
  // reset is asserted so the pipeline registers see a clean reset.
  // --------------------------------------------------------------------------
  always_comb begin
    stallf_o    = 1'b0;
    stalld_o    = 1'b0;
    stalle_o    = 1'b0;
    stallm_o    = 1'b0;
    flushd_o    = 1'b0;
    flushe_o    = 1'b0;
    flushw_o    = 1'b0;
    forwardae_o = 2'b00;
    forwardbe_o = 2'b00;

    if (!reset_i) begin
      if (memstall) begin
        // Freeze everything upstream of MEM; WB receives a bubble. A branch
        // redirect must wait until the memory access completes.
        stallf_o = 1'b1;
        stalld_o = 1'b1;
        stalle_o = 1'b1;
        stallm_o = 1'b1;
        flushw_o = 1'b1;
      end else begin
        stallf_o = lwstall;
        stalld_o = lwstall;
        flushd_o = pcsrce_i;
        flushe_o = lwstall | pcsrce_i;
      end

      // MEM result is younger, so it wins over WB; x0 is never forwarded.
      if (regwritem_i && (rdm_i != 5'd0) && (rdm_i == rs1e_i)) begin
        forwardae_o = 2'b10;
      end else if (regwritew_i && (rdw_i != 5'd0) && (rdw_i == rs1e_i)) begin
        forwardae_o = 2'b01;
      end

      if (regwritem_i && (rdm_i != 5'd0) && (rdm_i == rs2e_i)) begin
        forwardbe_o = 2'b10;
      end else if (regwritew_i && (rdw_i != 5'd0) && (rdw_i == rs2e_i)) begin
        forwardbe_o = 2'b01;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory wait FSM, error flag and stall counter: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    // Error flag is a registered copy of the ERR state, held forever.
    memerr_d   = memerr_q | (state_q == ST_ERR);
    stallcnt_d = stallcnt_q;

    case (state_q)
      ST_RUN: begin
        if (memreqm_i && !memreadym_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (memreadym_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (memstall && (stallcnt_q != {CNT_W{1'b1}})) begin
      stallcnt_d = stallcnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      memerr_q   <= 1'b0;
      stallcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      memerr_q   <= memerr_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  assign memerr_o   = memerr_q;
  assign stallcnt_o = stallcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4,
//             CNT_W=3). The driver pushes hand-computed expected output
//             vectors; a monitor pops and compares them on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;

  logic       clk;
  logic       reset_i;
  logic [4:0] rs1d_i, rs2d_i, rs1e_i, rs2e_i, rde_i, rdm_i, rdw_i;
  logic       resultsrce0_i, pcsrce_i, regwritem_i, regwritew_i;
  logic       memreqm_i, memreadym_i;

  logic             stallf_o, stalld_o, stalle_o, stallm_o;
  logic             flushd_o, flushe_o, flushw_o;
  logic [1:0]       forwardae_o, forwardbe_o;
  logic             memerr_o;
  logic [CNT_W-1:0] stallcnt_o;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .rs1d_i        (rs1d_i),
    .rs2d_i        (rs2d_i),
    .rs1e_i        (rs1e_i),
    .rs2e_i        (rs2e_i),
    .rde_i         (rde_i),
    .resultsrce0_i (resultsrce0_i),
    .pcsrce_i      (pcsrce_i),
    .regwritem_i   (regwritem_i),
    .rdm_i         (rdm_i),
    .regwritew_i   (regwritew_i),
    .rdw_i         (rdw_i),
    .memreqm_i     (memreqm_i),
    .memreadym_i   (memreadym_i),
    .stallf_o      (stallf_o),
    .stalld_o      (stalld_o),
    .stalle_o      (stalle_o),
    .stallm_o      (stallm_o),
    .flushd_o      (flushd_o),
    .flushe_o      (flushe_o),
    .flushw_o      (flushw_o),
    .forwardae_o   (forwardae_o),
    .forwardbe_o   (forwardbe_o),
    .memerr_o      (memerr_o),
    .stallcnt_o    (stallcnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stallf,stalld,stalle,stallm,flushd,flushe,flushw}
  localparam logic [6:0] SF_NONE = 7'b0000000;
  localparam logic [6:0] SF_LU   = 7'b1100010;
  localparam logic [6:0] SF_LUBR = 7'b1100110;
  localparam logic [6:0] SF_BR   = 7'b0000110;
  localparam logic [6:0] SF_MS   = 7'b1111001;

  typedef struct {
    logic [14:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;

  wire [14:0] act = {stallf_o, stalld_o, stalle_o, stallm_o,
                     flushd_o, flushe_o, flushw_o,
                     forwardae_o, forwardbe_o, memerr_o, stallcnt_o};

  function automatic logic [14:0] ev(input logic [6:0] sf, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic me,
                                     input logic [2:0] c);
    return {sf, fa, fb, me, c};
  endfunction

  // Monitor: compare whatever expectation is pending at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (act !== cur.v) begin
        $display("FAIL %s: got %b expected %b (sf7|fa2|fb2|err|cnt3)",
                 cur.name, act, cur.v);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [14:0] v);
    exp_t e;
    e.v    = v;
    e.name = n;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic clr();
    rs1d_i = 0; rs2d_i = 0; rs1e_i = 0; rs2e_i = 0; rde_i = 0;
    rdm_i = 0; rdw_i = 0;
    resultsrce0_i = 0; pcsrce_i = 0; regwritem_i = 0; regwritew_i = 0;
    memreqm_i = 0; memreadym_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    reset_i = 1'b1;
    tick();

    // Reset held with every hazard condition active: outputs must be quiet.
    resultsrce0_i = 1; rde_i = 5; rs1d_i = 5; pcsrce_i = 1;
    memreqm_i = 1; memreadym_i = 0;
    regwritem_i = 1; rdm_i = 3; rs1e_i = 3; rs2e_i = 3;
    chk("reset_hold", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));
    reset_i = 1'b0;
    clr();

    // Load-use hazards
    resultsrce0_i = 1; rde_i = 5; rs1d_i = 5;
    chk("loaduse_rs1", ev(SF_LU, 2'b00, 2'b00, 1'b0, 3'd0));
    rs1d_i = 0; rs2d_i = 5;
    chk("loaduse_rs2", ev(SF_LU, 2'b00, 2'b00, 1'b0, 3'd0));
    rde_i = 0; rs2d_i = 0;
    chk("loaduse_x0", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));
    rde_i = 7; rs1d_i = 7; pcsrce_i = 1;
    chk("lw_and_branch", ev(SF_LUBR, 2'b00, 2'b00, 1'b0, 3'd0));
    clr();

    // Forwarding priority
    regwritem_i = 1; rdm_i = 3; regwritew_i = 1; rdw_i = 3; rs1e_i = 3; rs2e_i = 3;
    chk("fwd_mem", ev(SF_NONE, 2'b10, 2'b10, 1'b0, 3'd0));
    regwritem_i = 0;
    chk("fwd_wb", ev(SF_NONE, 2'b01, 2'b01, 1'b0, 3'd0));
    rdw_i = 0;
    chk("fwd_x0", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));
    regwritem_i = 1; rdm_i = 4; rs1e_i = 4; regwritew_i = 1; rdw_i = 6; rs2e_i = 6;
    chk("fwd_mix", ev(SF_NONE, 2'b10, 2'b01, 1'b0, 3'd0));
    clr();

    // Memory wait of 3 cycles
    memreqm_i = 1; memreadym_i = 0;
    chk("memwait_c1", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd0));
    chk("memwait_c2", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd1));
    chk("memwait_c3", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd2));
    memreadym_i = 1;
    chk("memwait_release", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd3));
    clr();
    chk("memwait_back_run", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd3));

    // Branch resolved while memory is stalling
    memreqm_i = 1; memreadym_i = 0; pcsrce_i = 1;
    chk("branch_memstall_run", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd3));
    chk("branch_memwait", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd4));
    memreadym_i = 1;
    chk("branch_ready", ev(SF_BR, 2'b00, 2'b00, 1'b0, 3'd5));
    clr();

    // Reset asserted mid-wait
    memreqm_i = 1; memreadym_i = 0;
    tick();
    reset_i = 1'b1;
    chk("reset_midwait", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd6));
    reset_i = 1'b0;
    clr();
    chk("post_reset_run", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));

    // Timeout (MEM_TIMEOUT=4) followed by counter saturation (CNT_W=3)
    memreqm_i = 1; memreadym_i = 0;
    chk("timeout_c1", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd0));
    chk("timeout_c2", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd1));
    chk("timeout_c3", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd2));
    chk("timeout_c4", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd3));
    memreadym_i = 1;
    chk("err_entry", ev(SF_MS, 2'b00, 2'b00, 1'b0, 3'd4));
    memreqm_i = 0;
    chk("err_sticky", ev(SF_MS, 2'b00, 2'b00, 1'b1, 3'd5));
    chk("err_cnt6", ev(SF_MS, 2'b00, 2'b00, 1'b1, 3'd6));
    chk("err_cnt7", ev(SF_MS, 2'b00, 2'b00, 1'b1, 3'd7));
    chk("sat_hold1", ev(SF_MS, 2'b00, 2'b00, 1'b1, 3'd7));
    chk("sat_hold2", ev(SF_MS, 2'b00, 2'b00, 1'b1, 3'd7));
    reset_i = 1'b1;
    chk("reset_in_err", ev(SF_NONE, 2'b00, 2'b00, 1'b1, 3'd7));
    reset_i = 1'b0;
    clr();
    chk("after_err_reset", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));
    memreqm_i = 1; memreadym_i = 1;
    chk("req_ready_same_cycle", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 3'd0));
    clr();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It generates stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus EX-stage forwarding selects. It contains a data-memory wait state machine with a timeout for multi-cycle loads and stores, and a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles tolerated in MEM_WAIT before entering ERR (>=2)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk_i  in  1  clock, all state on posedge
reset_i  in  1  synchronous, active-high reset
rs1d_i  in  5  rs1 of the instruction in ID
rs2d_i  in  5  rs2 of the instruction in ID
rs1e_i  in  5  rs1 of the instruction in EX
rs2e_i  in  5  rs2 of the instruction in EX
rde_i  in  5  rd of the instruction in EX
resultsrce0_i  in  1  instruction in EX is a load
pcsrce_i  in  1  branch/jump taken, resolved in EX
regwritem_i  in  1  MEM-stage instruction writes rd
rdm_i  in  5  rd of the instruction in MEM
regwritew_i  in  1  WB-stage instruction writes rd
rdw_i  in  5  rd of the instruction in WB
memreqm_i  in  1  MEM-stage instruction accesses data memory
memreadym_i  in  1  data memory completes the access this cycle
stallf_o  out  1  hold PC
stalld_o  out  1  hold IF/ID
stalle_o  out  1  hold ID/EX
stallm_o  out  1  hold EX/MEM
flushd_o  out  1  clear IF/ID
flushe_o  out  1  clear ID/EX
flushw_o  out  1  load a bubble into MEM/WB (rdw=0, no write)
forwardae_o  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
forwardbe_o  out  2  EX operand B select, same encoding
memerr_o  out  1  memory timeout; sticky until reset
stallcnt_o  out  CNT_W  saturating count of memstall cycles

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset → RUN, wait counter 0, memerr_o 0, stallcnt_o 0.
- While reset_i=1, all stall and flush outputs are 0 and forward selects are 00, regardless of inputs.
- RUN→MEM_WAIT when memreqm_i=1 and memreadym_i=0; otherwise stay in RUN. Entering MEM_WAIT loads the wait counter with 1.
- MEM_WAIT→RUN when memreadym_i=1. Otherwise the counter increments. When the counter equals MEM_TIMEOUT-1 with memreadym_i=0, the FSM goes to ERR.
- ERR is absorbing until reset. memerr_o=1 (registered, asserted the cycle after entry).
- memstall is combinational: (RUN & memreqm_i & !memreadym_i) | (MEM_WAIT & !memreadym_i) | ERR. A ready response releases the stall in the same cycle.
- lwstall = resultsrce0_i & rde_i!=0 & (rde_i==rs1d_i | rde_i==rs2d_i).
- Priority: memstall over lwstall and branch.
  - memstall=1: stallf/d/e/m=1, flushw=1, flushd=flushe=0.
  - Otherwise: stallf=stalld=lwstall, stalle=stallm=0, flushd=pcsrce_i, flushe=lwstall|pcsrce_i, flushw=0.
- lwstall and pcsrce_i together: flushd=1, flushe=1, stallf=stalld=1. The branch redirect wins because IF/ID is flushed.
- Forwarding (A; B identical with rs2e_i):
  - 10 if regwritem_i & rdm_i!=0 & rdm_i==rs1e_i;
  - else 01 if regwritew_i & rdw_i!=0 & rdw_i==rs1e_i;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
  - During memstall, forwarding stays as computed; consumers are stalled.
- stallcnt_o increments by 1 on each posedge where memstall=1 and reset_i=0. It saturates at all-ones.
- A reset asserted mid-wait or in ERR returns the FSM to RUN the next edge and clears the counters and memerr_o.
- Stall and flush outputs are combinational from state and inputs. There are no combinational paths from memerr_o.

Test Plan:
- Load-use: resultsrce0_i=1, rde_i=5, rs1d_i=5 → stallf=stalld=1, flushe=1, stalle=0. With rde_i=0, all three are 0.
- Forward priority: regwritem_i=1, rdm_i=3, regwritew_i=1, rdw_i=3, rs1e_i=3, rs2e_i=3 → forwardae=forwardbe=10. Then regwritem_i=0 → 01. Then rdw_i=0 → 00.
- Memory wait of 3 cycles: memreqm_i=1, memreadym_i low for 3 edges then high → stalls and flushw high for exactly 3 cycles, released the cycle ready=1, stallcnt_o=3, state RUN.
- Timeout with MEM_TIMEOUT=4: memreqm_i=1, ready never asserted → ERR after the 4th stalled edge, memerr_o=1 the following cycle, stalls held. reset_i for 1 edge → all outputs 0, memerr_o=0, stallcnt_o=0.
- Branch during memstall: pcsrce_i=1 while MEM_WAIT with ready=0 → flushd=flushe=0. On the ready cycle → flushd=flushe=1.
- Saturation with CNT_W=3: 9 memstall cycles → stallcnt_o stops at 7.
